// File: rtl/multicycle_control_unit.sv
// Multicycle instruction control unit: IDLE -> DECODE -> EXECUTE -> MEM -> WRITEBACK.
// Every output is registered from the next state and the latched opcode class,
// so instr_valid, opcode and mem_ready never reach an output combinationally.
module multicycle_control_unit #(
   parameter int OPCODE_W    = 4,
   parameter int ALU_OP_W    = 2,
   parameter int MEM_TIMEOUT = 8,
   parameter int CNT_W       = 16
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                instr_valid,
   input  logic [OPCODE_W-1:0] opcode,
   output logic                instr_ready,
   input  logic                mem_ready,
   output logic                reg_write_enable,
   output logic [ALU_OP_W-1:0] alu_op,
   output logic                mem_read,
   output logic                mem_write,
   output logic [1:0]          mux_sel,
   output logic                busy,
   output logic                illegal_op,
   output logic                timeout_err,
   output logic [CNT_W-1:0]    retired_cnt
);

   localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_DECODE    = 3'd1,
      S_EXECUTE   = 3'd2,
      S_MEM       = 3'd3,
      S_WRITEBACK = 3'd4
   } state_t;

   typedef enum logic [2:0] {
      OP_ADD   = 3'd0,
      OP_SUB   = 3'd1,
      OP_LOAD  = 3'd2,
      OP_STORE = 3'd3,
      OP_NOP   = 3'd4,
      OP_ILL   = 3'd5
   } op_t;

   // Map a raw opcode to its class; any set bit above the defined codes is illegal.
   function automatic op_t decode_op(input logic [OPCODE_W-1:0] code);
      op_t res;
      case (code)
         OPCODE_W'(0): res = OP_ADD;
         OPCODE_W'(1): res = OP_SUB;
         OPCODE_W'(2): res = OP_LOAD;
         OPCODE_W'(3): res = OP_STORE;
         OPCODE_W'(4): res = OP_NOP;
         default:      res = OP_ILL;
      endcase
      return res;
   endfunction

   state_t              state_r, state_nxt_s;
   op_t                 op_r, op_nxt_s;
   logic [WAIT_W-1:0]   wait_r, wait_nxt_s;
   logic                retire_s, ill_nxt_s, tmo_nxt_s;
   logic                ready_nxt_s, busy_nxt_s, we_nxt_s, rd_nxt_s, wr_nxt_s;
   logic [ALU_OP_W-1:0] alu_nxt_s;
   logic [1:0]          mux_nxt_s;

   // Next-state, opcode latch, MEM wait counter, retire and error-pulse decisions.
   always_comb begin
      state_nxt_s = state_r;
      op_nxt_s    = op_r;
      wait_nxt_s  = wait_r;
      retire_s    = 1'b0;
      ill_nxt_s   = 1'b0;
      tmo_nxt_s   = 1'b0;
      case (state_r)
         S_IDLE: begin
            // instr_ready is high throughout IDLE, so instr_valid alone completes the handshake
            if (instr_valid) begin
               op_nxt_s    = decode_op(opcode);
               state_nxt_s = S_DECODE;
            end else begin
               state_nxt_s = S_IDLE;
            end
         end
         S_DECODE: begin
            case (op_r)
               OP_ADD, OP_SUB, OP_LOAD, OP_STORE: state_nxt_s = S_EXECUTE;
               OP_NOP: begin
                  state_nxt_s = S_IDLE;
                  retire_s    = 1'b1;
               end
               default: begin
                  state_nxt_s = S_IDLE;
                  ill_nxt_s   = 1'b1;
               end
            endcase
         end
         S_EXECUTE: begin
            wait_nxt_s = WAIT_W'(0);
            if ((op_r == OP_LOAD) || (op_r == OP_STORE)) begin
               state_nxt_s = S_MEM;
            end else begin
               state_nxt_s = S_WRITEBACK;
            end
         end
         S_MEM: begin
            // A completion in the last allowed cycle wins over the timeout
            if (mem_ready) begin
               if (op_r == OP_LOAD) begin
                  state_nxt_s = S_WRITEBACK;
               end else begin
                  state_nxt_s = S_IDLE;
                  retire_s    = 1'b1;
               end
            end else if (wait_r == WAIT_LAST) begin
               state_nxt_s = S_IDLE;
               tmo_nxt_s   = 1'b1;
            end else begin
               wait_nxt_s = wait_r + WAIT_W'(1);
            end
         end
         S_WRITEBACK: begin
            state_nxt_s = S_IDLE;
            retire_s    = 1'b1;
         end
         default: state_nxt_s = S_IDLE;
      endcase
   end

   // Control outputs for the state being entered, from that state and the latched opcode class.
   always_comb begin
      ready_nxt_s = 1'b0;
      busy_nxt_s  = 1'b1;
      we_nxt_s    = 1'b0;
      rd_nxt_s    = 1'b0;
      wr_nxt_s    = 1'b0;
      alu_nxt_s   = ALU_OP_W'(0);
      mux_nxt_s   = 2'b00;
      case (state_nxt_s)
         S_IDLE: begin
            ready_nxt_s = 1'b1;
            busy_nxt_s  = 1'b0;
         end
         S_DECODE: busy_nxt_s = 1'b1;
         S_EXECUTE: begin
            alu_nxt_s = (op_nxt_s == OP_SUB) ? ALU_OP_W'(1) : ALU_OP_W'(0);
            mux_nxt_s = ((op_nxt_s == OP_LOAD) || (op_nxt_s == OP_STORE)) ? 2'b01 : 2'b00;
         end
         S_MEM: begin
            rd_nxt_s  = (op_nxt_s == OP_LOAD);
            wr_nxt_s  = (op_nxt_s == OP_STORE);
            mux_nxt_s = 2'b01;
         end
         S_WRITEBACK: begin
            we_nxt_s  = 1'b1;
            mux_nxt_s = (op_nxt_s == OP_LOAD) ? 2'b10 : 2'b00;
         end
         default: begin
            ready_nxt_s = 1'b0;
            busy_nxt_s  = 1'b0;
         end
      endcase
   end

   // State, opcode class, wait counter, registered outputs and retire counter.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r          <= S_IDLE;
         op_r             <= OP_NOP;
         wait_r           <= WAIT_W'(0);
         instr_ready      <= 1'b1;
         busy             <= 1'b0;
         reg_write_enable <= 1'b0;
         mem_read         <= 1'b0;
         mem_write        <= 1'b0;
         alu_op           <= ALU_OP_W'(0);
         mux_sel          <= 2'b00;
         illegal_op       <= 1'b0;
         timeout_err      <= 1'b0;
         retired_cnt      <= CNT_W'(0);
      end else begin
         state_r          <= state_nxt_s;
         op_r             <= op_nxt_s;
         wait_r           <= wait_nxt_s;
         instr_ready      <= ready_nxt_s;
         busy             <= busy_nxt_s;
         reg_write_enable <= we_nxt_s;
         mem_read         <= rd_nxt_s;
         mem_write        <= wr_nxt_s;
         alu_op           <= alu_nxt_s;
         mux_sel          <= mux_nxt_s;
         illegal_op       <= ill_nxt_s;
         timeout_err      <= tmo_nxt_s;
         if (retire_s) begin
            retired_cnt <= retired_cnt + CNT_W'(1);
         end else begin
            retired_cnt <= retired_cnt;
         end
      end
   end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed, table-driven bench for multicycle_control_unit, plus hand-written
// sequences for reset during MEM, reset against a handshake and counter wrap.
module tb_multicycle_control_unit;

   localparam int CNT_W = 16;
   localparam int NEVER = 255;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n, instr_valid, mem_ready;
   logic [3:0] opcode;

   logic             instr_ready, reg_write_enable, mem_read, mem_write, busy, illegal_op, timeout_err;
   logic [1:0]       alu_op, mux_sel;
   logic [CNT_W-1:0] retired_cnt;

   logic       b_instr_ready, b_reg_write_enable, b_mem_read, b_mem_write, b_busy, b_illegal_op, b_timeout_err;
   logic [1:0] b_alu_op, b_mux_sel, b_retired_cnt;

   multicycle_control_unit #(.OPCODE_W(4), .ALU_OP_W(2), .MEM_TIMEOUT(8), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .opcode(opcode),
      .instr_ready(instr_ready), .mem_ready(mem_ready), .reg_write_enable(reg_write_enable),
      .alu_op(alu_op), .mem_read(mem_read), .mem_write(mem_write), .mux_sel(mux_sel),
      .busy(busy), .illegal_op(illegal_op), .timeout_err(timeout_err), .retired_cnt(retired_cnt)
   );

   multicycle_control_unit #(.OPCODE_W(4), .ALU_OP_W(2), .MEM_TIMEOUT(8), .CNT_W(2)) dut2 (
      .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .opcode(opcode),
      .instr_ready(b_instr_ready), .mem_ready(mem_ready), .reg_write_enable(b_reg_write_enable),
      .alu_op(b_alu_op), .mem_read(b_mem_read), .mem_write(b_mem_write), .mux_sel(b_mux_sel),
      .busy(b_busy), .illegal_op(b_illegal_op), .timeout_err(b_timeout_err), .retired_cnt(b_retired_cnt)
   );

   typedef struct {
      logic [3:0] op;
      int         w;      // MEM cycles with mem_ready low before it rises (NEVER = never)
      int         lat;    // cycle at which instr_ready is high again
      int         rd;
      int         wr;
      int         we;
      int         ill;
      int         tmo;
      int         dret;
      logic [1:0] alu2;   // alu_op at cycle 2
      logic [1:0] mux2;   // mux_sel at cycle 2
      logic [1:0] muxwb;  // mux_sel during WRITEBACK (11 when none)
   } vec_t;

   vec_t             vecs [13];
   int               checks = 0;
   int               errors = 0;
   logic [CNT_W-1:0] exp_cnt;

   task automatic check(input string name, input longint act, input longint exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic run_instr(input vec_t v, input string tag);
      int         cyc, mcnt, nrd, nwr, nwe, nill, ntmo, bad_busy, bad_mem_mux, bad_dec;
      logic [1:0] alu2, mux2, muxwb;
      logic       done;
      cyc = 0; mcnt = 0; nrd = 0; nwr = 0; nwe = 0; nill = 0; ntmo = 0;
      bad_busy = 0; bad_mem_mux = 0; bad_dec = 0;
      alu2 = 2'b00; mux2 = 2'b00; muxwb = 2'b11; done = 1'b0;
      @(negedge clk);
      check({tag, " ready_before"}, instr_ready, 1);
      instr_valid = 1'b1;
      opcode      = v.op;
      mem_ready   = 1'b0;
      @(posedge clk);
      while (!done && cyc < 40) begin
         @(negedge clk);
         cyc++;
         instr_valid = 1'b0;
         opcode      = 4'($urandom_range(0, 15));
         if (busy === instr_ready) bad_busy++;
         nrd  += int'(mem_read);
         nwr  += int'(mem_write);
         nwe  += int'(reg_write_enable);
         nill += int'(illegal_op);
         ntmo += int'(timeout_err);
         if (cyc == 1 && (reg_write_enable || mem_read || mem_write || alu_op != 2'b00 ||
                          mux_sel != 2'b00 || illegal_op || timeout_err || instr_ready)) bad_dec++;
         if (cyc == 2) begin
            alu2 = alu_op;
            mux2 = mux_sel;
         end
         if (reg_write_enable) muxwb = mux_sel;
         if ((mem_read || mem_write) && mux_sel != 2'b01) bad_mem_mux++;
         if (mem_read || mem_write) begin
            mcnt++;
            mem_ready = (v.w != NEVER) && (mcnt > v.w);
         end else begin
            mem_ready = 1'b0;
         end
         if (instr_ready) done = 1'b1;
      end
      // One more idle cycle so a pulse longer than one cycle is counted
      @(negedge clk);
      nill += int'(illegal_op);
      ntmo += int'(timeout_err);
      exp_cnt = exp_cnt + CNT_W'(v.dret);
      check({tag, " latency"}, cyc, v.lat);
      check({tag, " mem_read_cycles"}, nrd, v.rd);
      check({tag, " mem_write_cycles"}, nwr, v.wr);
      check({tag, " reg_we_cycles"}, nwe, v.we);
      check({tag, " illegal_pulses"}, nill, v.ill);
      check({tag, " timeout_pulses"}, ntmo, v.tmo);
      check({tag, " alu_op_c2"}, alu2, v.alu2);
      check({tag, " mux_sel_c2"}, mux2, v.mux2);
      check({tag, " mux_sel_wb"}, muxwb, v.muxwb);
      check({tag, " busy_vs_ready"}, bad_busy, 0);
      check({tag, " mux_sel_mem"}, bad_mem_mux, 0);
      check({tag, " decode_outputs"}, bad_dec, 0);
      check({tag, " retired_cnt"}, retired_cnt, exp_cnt);
      check({tag, " retired_cnt_w2"}, b_retired_cnt, exp_cnt[1:0]);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int seq [5];
      seq = '{1, 2, 3, 0, 1};
      //            op       w      lat rd wr we il tm dr alu2   mux2   muxwb
      vecs[0]  = '{4'b0000, 0,     4,  0, 0, 1, 0, 0, 1, 2'b00, 2'b00, 2'b00};
      vecs[1]  = '{4'b0001, 0,     4,  0, 0, 1, 0, 0, 1, 2'b01, 2'b00, 2'b00};
      vecs[2]  = '{4'b0010, 0,     5,  1, 0, 1, 0, 0, 1, 2'b00, 2'b01, 2'b10};
      vecs[3]  = '{4'b0010, 2,     7,  3, 0, 1, 0, 0, 1, 2'b00, 2'b01, 2'b10};
      vecs[4]  = '{4'b0011, 0,     4,  0, 1, 0, 0, 0, 1, 2'b00, 2'b01, 2'b11};
      vecs[5]  = '{4'b0011, NEVER, 11, 0, 8, 0, 0, 1, 0, 2'b00, 2'b01, 2'b11};
      vecs[6]  = '{4'b0011, 7,     11, 0, 8, 0, 0, 0, 1, 2'b00, 2'b01, 2'b11};
      vecs[7]  = '{4'b0010, NEVER, 11, 8, 0, 0, 0, 1, 0, 2'b00, 2'b01, 2'b11};
      vecs[8]  = '{4'b0010, 7,     12, 8, 0, 1, 0, 0, 1, 2'b00, 2'b01, 2'b10};
      vecs[9]  = '{4'b0100, 0,     2,  0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b11};
      vecs[10] = '{4'b1111, 0,     2,  0, 0, 0, 1, 0, 0, 2'b00, 2'b00, 2'b11};
      vecs[11] = '{4'b0101, 0,     2,  0, 0, 0, 1, 0, 0, 2'b00, 2'b00, 2'b11};
      vecs[12] = '{4'b1000, 0,     2,  0, 0, 0, 1, 0, 0, 2'b00, 2'b00, 2'b11};

      rst_n = 1'b0; instr_valid = 1'b0; mem_ready = 1'b0; opcode = 4'b0000;
      exp_cnt = '0;
      repeat (2) @(negedge clk);
      check("reset instr_ready", instr_ready, 1);
      check("reset busy", busy, 0);
      check("reset strobes", {reg_write_enable, mem_read, mem_write, illegal_op, timeout_err}, 0);
      check("reset alu_mux", {alu_op, mux_sel}, 0);
      check("reset retired_cnt", retired_cnt, 0);
      rst_n = 1'b1;

      for (int i = 0; i < 13; i++) begin
         run_instr(vecs[i], $sformatf("vec%0d", i));
      end

      // Reset while a LOAD sits in MEM, with mem_ready raised on the same edge
      @(negedge clk);
      instr_valid = 1'b1; opcode = 4'b0010;
      @(posedge clk);
      @(negedge clk); instr_valid = 1'b0;
      repeat (3) @(negedge clk);
      check("midrst mem_read_before", mem_read, 1);
      rst_n = 1'b0; mem_ready = 1'b1;
      @(negedge clk);
      rst_n = 1'b1; mem_ready = 1'b0;
      exp_cnt = '0;
      check("midrst instr_ready", instr_ready, 1);
      check("midrst strobes", {reg_write_enable, mem_read, mem_write, illegal_op, timeout_err}, 0);
      check("midrst retired_cnt", retired_cnt, 0);
      @(negedge clk);
      check("midrst quiet", {busy, reg_write_enable, mem_read, illegal_op, timeout_err}, 0);
      run_instr(vecs[0], "post_rst_add");

      // Reset wins over a simultaneous handshake
      @(negedge clk);
      rst_n = 1'b0; instr_valid = 1'b1; opcode = 4'b0000;
      @(negedge clk);
      rst_n = 1'b1; instr_valid = 1'b0;
      exp_cnt = '0;
      check("rst_vs_hs ready", instr_ready, 1);
      @(negedge clk);
      check("rst_vs_hs busy", busy, 0);
      check("rst_vs_hs cnt", retired_cnt, 0);

      // Narrow counter wraps after four retires
      for (int i = 0; i < 5; i++) begin
         run_instr(vecs[9], $sformatf("nop_wrap%0d", i));
         check($sformatf("wrap_seq%0d", i), b_retired_cnt, seq[i]);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/multicycle_control_unit.md
MULTICYCLE_CONTROL_UNIT -- requirements
Module: multicycle_control_unit

Interface
REQ-001 Parameter OPCODE_W, 4, opcode width; SHALL be 4 or greater, with upper bits above bit 3 required zero for legal opcodes.
REQ-002 Parameter ALU_OP_W, 2, alu_op width; SHALL be 1 or greater.
REQ-003 Parameter MEM_TIMEOUT, 8, MEM-state cycles without mem_ready before abort; SHALL be 1 or greater.
REQ-004 Parameter CNT_W, 16, retired-instruction counter width.
REQ-005 The block SHALL use one clock; reset is synchronous and active-low.
REQ-006 clk  in  1  rising-edge clock.
REQ-007 rst_n  in  1  synchronous active-low reset.
REQ-008 instr_valid  in  1  opcode offered.
REQ-009 opcode  in  OPCODE_W  instruction opcode, sampled on handshake.
REQ-010 instr_ready  out  1  block can accept; high only in IDLE.
REQ-011 mem_ready  in  1  memory access complete; honoured only in MEM.
REQ-012 reg_write_enable  out  1  register-file write strobe.
REQ-013 alu_op  out  ALU_OP_W  ALU operation select.
REQ-014 mem_read  out  1  memory read request.
REQ-015 mem_write  out  1  memory write request.
REQ-016 mux_sel  out  2  writeback/operand mux select.
REQ-017 busy  out  1  high in any state other than IDLE.
REQ-018 illegal_op  out  1  one-cycle pulse on an undefined opcode.
REQ-019 timeout_err  out  1  one-cycle pulse on a memory timeout abort.
REQ-020 retired_cnt  out  CNT_W  count of completed instructions.

Function
REQ-021 States SHALL be IDLE, DECODE, EXECUTE, MEM and WRITEBACK.
REQ-022 Opcodes SHALL decode as follows:
- 0000 ADD
- 0001 SUB
- 0010 LOAD
- 0011 STORE
- 0100 NOP
- all other values illegal.
REQ-023 Handshake: instr_valid and instr_ready both high at an edge SHALL latch opcode and move IDLE to DECODE; opcode changes at any other time SHALL be ignored.
REQ-024 DECODE SHALL last one cycle with all control outputs at 0.
REQ-025 DECODE next-state rules:
- ADD, SUB, LOAD or STORE: go to EXECUTE.
- NOP: go to IDLE and retire.
- Illegal: go to IDLE with illegal_op high for exactly the first IDLE cycle.
REQ-026 EXECUTE SHALL last one cycle with these outputs:
- alu_op = 0 for ADD, LOAD and STORE; alu_op = 1 for SUB.
- mux_sel = 00 for ADD and SUB; mux_sel = 01 for LOAD and STORE.
REQ-027 EXECUTE next-state rules: ADD and SUB go to WRITEBACK; LOAD and STORE go to MEM.
REQ-028 MEM SHALL hold mem_read=1 for LOAD or mem_write=1 for STORE, and mux_sel = 01, continuously until exit.
REQ-029 MEM exit on mem_ready=1 at an edge:
- LOAD goes to WRITEBACK.
- STORE goes to IDLE and retires.
- mem_ready already high on the first MEM cycle gives a 1-cycle MEM.
REQ-030 MEM timeout: a wait counter SHALL clear on MEM entry and increment on each MEM cycle with mem_ready=0.
- After MEM_TIMEOUT consecutive such cycles: go to IDLE, no writeback, no retire, timeout_err high for the first IDLE cycle.
- mem_ready=1 in that final cycle SHALL take priority over the timeout.
REQ-031 WRITEBACK SHALL last one cycle with reg_write_enable=1.
- mux_sel = 00 for ADD and SUB; mux_sel = 10 for LOAD.
- Next state IDLE, and the instruction retires.
REQ-032 All control outputs SHALL be 0 in any state or condition not named above.
REQ-033 Outputs SHALL be registered or decoded purely from state and latched opcode, with no combinational path from instr_valid, opcode or mem_ready to any output.
REQ-034 retired_cnt SHALL increment by 1 on each retire edge and wrap modulo 2^CNT_W.
REQ-035 Latencies, with the handshake edge at cycle 0:
- NOP: instr_ready high again at cycle 2.
- ADD and SUB: cycle 4.
- LOAD and STORE with zero wait: cycle 5 and cycle 4 respectively.
REQ-036 Back-to-back throughput SHALL be limited by instr_ready, which is high only in IDLE.

Reset
REQ-037 With rst_n=0 at an edge the block SHALL return to IDLE.
- All outputs 0 except instr_ready=1.
- retired_cnt and the wait counter cleared.
REQ-038 Reset mid-operation (any state) SHALL discard the in-flight instruction with no retire, no error pulse and no memory strobe after that edge.
REQ-039 rst_n=0 SHALL override a simultaneous handshake or mem_ready.

Verification
REQ-040 ADD (0000) accepted at cycle 0 -> DECODE at cycle 1, EXECUTE alu_op=0 mux_sel=00 at cycle 2, WRITEBACK reg_write_enable=1 at cycle 3, instr_ready=1 and retired_cnt=1 at cycle 4.
REQ-041 LOAD (0010) with mem_ready after 3 MEM cycles -> mem_read=1 for exactly 3 cycles, then WRITEBACK with mux_sel=10, then retired_cnt+1.
REQ-042 STORE (0011) with MEM_TIMEOUT=8 and mem_ready never asserted -> mem_write=1 for 8 cycles, timeout_err pulse of 1 cycle, retired_cnt unchanged, no reg_write_enable.
REQ-043 Opcode 1111 -> illegal_op pulse of 1 cycle at cycle 2, no control strobes, retired_cnt unchanged; NOP (0100) -> ready at cycle 2, retired_cnt+1.
REQ-044 rst_n=0 for 1 cycle during LOAD MEM -> next cycle IDLE, mem_read=0, retired_cnt=0; a new ADD then completes normally.
REQ-045 CNT_W=2 with 5 NOPs -> retired_cnt sequence 1,2,3,0,1.
